// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter: FSM states,
// arbitration modes, response owner tags and the byte-merge used by
// read-modify-write stores.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RMW_CAP = 2'd1,
        RMW_WR  = 2'd2
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Per byte lane: new store data where the enable is set, else the old word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                                input logic [31:0] rdata,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? wdata[8*b +: 8] : rdata[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Core-side memory interface: instruction-fetch port and load/store port.
// The core drives the master modport, the arbiter sits on the slave modport.
interface sram_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    import sram_arb_pkg::*;

    logic                  i_req;
    logic [ADDR_WIDTH+1:0] i_addr;
    logic                  i_gnt;
    logic                  i_rvalid;
    logic [DATA_WIDTH-1:0] i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [3:0]            d_be;
    logic [ADDR_WIDTH+1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata
    );

endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-requester grant logic. Fixed mode always favours the data port;
// round-robin mode alternates on contested cycles using a last-grant pointer.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    // 1 when the last contested grant went to the instruction port, so the
    // next contested grant goes to data; reset value makes data win first.
    logic last_i;

    // Grant is purely combinational from the requests and the enable.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (en) begin
            if (d_req && i_req) begin
                if (ARB_MODE == ARB_RR && !last_i) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // Pointer moves only when both ports competed for the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_i <= 1'b1;
        end else if (en && i_req && d_req) begin
            last_i <= i_gnt;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single-port 1RW SRAM macro between instruction fetch and
// load/store. Reads are fully pipelined (grant in A, response in A+2);
// sub-word stores are done as read-modify-write because the macro has no mask.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ARB_MODE   = ARB_FIXED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_port_arbiter_if.slave    bus,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    state_t                state_q, state_d;
    logic                  i_gnt, d_gnt, arb_en;
    logic                  csb_c, web_c;
    logic [ADDR_WIDTH-1:0] addr_c, addr_hold;
    logic [DATA_WIDTH-1:0] din_c, din_hold;
    logic                  rd_issue, rmw_start, store_ack;
    owner_t                rd_own;
    logic                  rd_vld_p1;
    owner_t                rd_own_p1;
    logic                  i_rvalid_q, d_rvalid_q;
    logic [DATA_WIDTH-1:0] i_rdata_q, d_rdata_q;
    logic [ADDR_WIDTH-1:0] rmw_addr_q;
    logic [3:0]            rmw_be_q;
    logic [DATA_WIDTH-1:0] rmw_wdata_q, merged_q;
    logic                  addr_lsb_unused;

    // Word addressing: the byte offset bits carry no information here.
    assign addr_lsb_unused = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    assign arb_en = rst_n && (state_q == IDLE);

    sram_rr_arbiter #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .i_req (bus.i_req),
        .d_req (bus.d_req),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    // Next state and SRAM pin drive for the current access cycle.
    always_comb begin
        state_d   = state_q;
        csb_c     = 1'b1;
        web_c     = 1'b1;
        addr_c    = addr_hold;
        din_c     = din_hold;
        rd_issue  = 1'b0;
        rd_own    = OWN_I;
        rmw_start = 1'b0;
        store_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    if (!bus.d_we) begin
                        csb_c    = 1'b0;
                        addr_c   = bus.d_addr[ADDR_WIDTH+1:2];
                        rd_issue = 1'b1;
                        rd_own   = OWN_D;
                    end else if (bus.d_be == 4'hF) begin
                        csb_c     = 1'b0;
                        web_c     = 1'b0;
                        addr_c    = bus.d_addr[ADDR_WIDTH+1:2];
                        din_c     = bus.d_wdata;
                        store_ack = 1'b1;
                    end else if (bus.d_be == 4'h0) begin
                        store_ack = 1'b1;
                    end else begin
                        csb_c     = 1'b0;
                        addr_c    = bus.d_addr[ADDR_WIDTH+1:2];
                        rmw_start = 1'b1;
                        state_d   = RMW_CAP;
                    end
                end else if (i_gnt) begin
                    csb_c    = 1'b0;
                    addr_c   = bus.i_addr[ADDR_WIDTH+1:2];
                    rd_issue = 1'b1;
                    rd_own   = OWN_I;
                end
            end
            RMW_CAP: begin
                state_d = RMW_WR;
            end
            RMW_WR: begin
                csb_c   = 1'b0;
                web_c   = 1'b0;
                addr_c  = rmw_addr_q;
                din_c   = merged_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset must deselect the macro immediately, without waiting for a clock.
    assign sram_csb  = rst_n ? csb_c : 1'b1;
    assign sram_web  = rst_n ? web_c : 1'b1;
    assign sram_addr = addr_c;
    assign sram_din  = din_c;

    assign bus.i_gnt    = i_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

    // Control state: FSM, read owner tag pipeline and response valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_vld_p1  <= 1'b0;
            rd_own_p1  <= OWN_I;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // stage p1: macro output becomes valid in this cycle
            rd_vld_p1  <= rd_issue;
            rd_own_p1  <= rd_own;
            i_rvalid_q <= rd_vld_p1 && (rd_own_p1 == OWN_I);
            d_rvalid_q <= (rd_vld_p1 && (rd_own_p1 == OWN_D)) || store_ack ||
                          (state_q == RMW_WR);
        end
    end

    // Datapath registers: held pins, RMW operands and captured read data.
    always_ff @(posedge clk) begin
        if (!csb_c) begin
            addr_hold <= addr_c;
            din_hold  <= din_c;
        end
        if (rmw_start) begin
            rmw_addr_q  <= bus.d_addr[ADDR_WIDTH+1:2];
            rmw_be_q    <= bus.d_be;
            rmw_wdata_q <= bus.d_wdata;
        end
        if (state_q == RMW_CAP) begin
            merged_q <= merge_bytes(rmw_wdata_q, sram_dout, rmw_be_q);
        end
        if (rd_vld_p1 && (rd_own_p1 == OWN_I)) begin
            i_rdata_q <= sram_dout;
        end
        if (rd_vld_p1 && (rd_own_p1 == OWN_D)) begin
            d_rdata_q <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: one fixed-priority and one round-robin
// instance, each with its own behavioural SRAM macro, directed scenarios
// followed by random single transactions against a reference memory.
module tb_sram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n;
    int   total = 0;
    int   bad   = 0;

    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

    logic          csb0, web0, csb1, web1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, din1, dout0, dout1;
    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] ref0 [256];
    int            wr_cnt0 = 0;

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(bus0),
        .sram_csb(csb0), .sram_web(web0), .sram_addr(addr0),
        .sram_din(din0), .sram_dout(dout0)
    );

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(bus1),
        .sram_csb(csb1), .sram_web(web1), .sram_addr(addr1),
        .sram_din(din1), .sram_dout(dout1)
    );

    // 1RW macro models: pins sampled at the clock edge, read data after it.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                mem0[addr0] <= din0;
                wr_cnt0     <= wr_cnt0 + 1;
            end else begin
                dout0 <= mem0[addr0];
            end
        end
        if (!csb1) begin
            if (!web1) mem1[addr1] <= din1;
            else       dout1 <= mem1[addr1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on the fixed-priority instance, checked against ref0.
    // kind: 0 fetch, 1 load, 2 store.
    task automatic txn0(input int kind, input logic [7:0] w,
                        input logic [3:0] be, input logic [31:0] wd);
        int          lat;
        int          exp_lat;
        logic        got;
        logic [31:0] exp;
        @(negedge clk);
        if (kind == 0) begin
            bus0.i_req  = 1'b1;
            bus0.i_addr = {w, 2'b00};
        end else begin
            bus0.d_req   = 1'b1;
            bus0.d_we    = (kind == 2);
            bus0.d_be    = be;
            bus0.d_addr  = {w, 2'b01};
            bus0.d_wdata = wd;
        end
        #1;
        chk("rnd_gnt", (kind == 0) ? bus0.i_gnt : bus0.d_gnt, 32'd1);
        exp = ref0[w];
        if (kind == 2) begin
            exp_lat = (be == 4'hF || be == 4'h0) ? 1 : 3;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref0[w][8*b +: 8] = wd[8*b +: 8];
        end else begin
            exp_lat = 2;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            bus0.i_req = 1'b0;
            bus0.d_req = 1'b0;
            #1;
            lat++;
            got = (kind == 0) ? bus0.i_rvalid : bus0.d_rvalid;
        end
        chk("rnd_latency", lat, exp_lat);
        if (kind == 0)      chk("rnd_i_rdata", bus0.i_rdata, exp);
        else if (kind == 1) chk("rnd_d_rdata", bus0.d_rdata, exp);
    endtask

    initial begin
        int          wsave;
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v       = $urandom;
            mem0[i] = v;
            ref0[i] = v;
            mem1[i] = $urandom;
        end
        bus0.i_addr = '0; bus0.d_we = 1'b0; bus0.d_be = 4'h0;
        bus0.d_addr = '0; bus0.d_wdata = '0;
        bus1.i_addr = '0; bus1.d_we = 1'b0; bus1.d_be = 4'h0;
        bus1.d_addr = '0; bus1.d_wdata = '0;

        // Reset held with both ports requesting
        rst0_n = 1'b0; rst1_n = 1'b0;
        bus0.i_req = 1'b1; bus0.d_req = 1'b1;
        bus1.i_req = 1'b1; bus1.d_req = 1'b1;
        #1;
        chk("rst_csb0", csb0, 1'b1);
        chk("rst_web0", web0, 1'b1);
        chk("rst_csb1", csb1, 1'b1);
        chk("rst_gnt0", {bus0.i_gnt, bus0.d_gnt}, 2'b00);
        chk("rst_gnt1", {bus1.i_gnt, bus1.d_gnt}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid0", {bus0.i_rvalid, bus0.d_rvalid}, 2'b00);
        chk("rst_valid1", {bus1.i_rvalid, bus1.d_rvalid}, 2'b00);

        // Release: data first in both modes, then fixed stays on D and RR alternates
        rst0_n = 1'b1; rst1_n = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk("fix_d_gnt", bus0.d_gnt, 1'b1);
            chk("fix_i_gnt", bus0.i_gnt, 1'b0);
            chk("rr_d_gnt", bus1.d_gnt, (k % 2 == 0));
            chk("rr_i_gnt", bus1.i_gnt, (k % 2 == 1));
        end
        @(negedge clk);
        bus0.i_req = 1'b0; bus0.d_req = 1'b0;
        bus1.i_req = 1'b0; bus1.d_req = 1'b0;
        repeat (3) @(negedge clk);

        // Single fetch of word 4
        mem0[4] = 32'hDEADBEEF; ref0[4] = 32'hDEADBEEF;
        bus0.i_req = 1'b1; bus0.i_addr = 10'h010;
        #1;
        chk("f_gnt", bus0.i_gnt, 1'b1);
        chk("f_csb", csb0, 1'b0);
        chk("f_web", web0, 1'b1);
        chk("f_addr", addr0, 8'h04);
        @(negedge clk); bus0.i_req = 1'b0; #1;
        chk("f_valid_a1", bus0.i_rvalid, 1'b0);
        @(negedge clk); #1;
        chk("f_valid_a2", bus0.i_rvalid, 1'b1);
        chk("f_rdata", bus0.i_rdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("f_valid_pulse", bus0.i_rvalid, 1'b0);

        // Fixed priority with contention: D load word 2, I fetch word 1
        mem0[1] = 32'hA1A1A1A1; ref0[1] = 32'hA1A1A1A1;
        mem0[2] = 32'hB2B2B2B2; ref0[2] = 32'hB2B2B2B2;
        @(negedge clk);
        bus0.i_req = 1'b1; bus0.i_addr = 10'h004;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 10'h008;
        #1;
        chk("pri_d_gnt", bus0.d_gnt, 1'b1);
        chk("pri_i_wait", bus0.i_gnt, 1'b0);
        chk("pri_addr_d", addr0, 8'h02);
        @(negedge clk); bus0.d_req = 1'b0; #1;
        chk("pri_i_gnt", bus0.i_gnt, 1'b1);
        chk("pri_addr_i", addr0, 8'h01);
        @(negedge clk); bus0.i_req = 1'b0; #1;
        chk("pri_d_valid", bus0.d_rvalid, 1'b1);
        chk("pri_d_rdata", bus0.d_rdata, 32'hB2B2B2B2);
        chk("pri_i_early", bus0.i_rvalid, 1'b0);
        @(negedge clk); #1;
        chk("pri_i_valid", bus0.i_rvalid, 1'b1);
        chk("pri_i_rdata", bus0.i_rdata, 32'hA1A1A1A1);
        chk("pri_d_pulse", bus0.d_rvalid, 1'b0);

        // Partial store to word 8 by read-modify-write
        mem0[8] = 32'h11223344; ref0[8] = 32'h1122AB44;
        @(negedge clk);
        bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_be = 4'b0010;
        bus0.d_addr = 10'h020; bus0.d_wdata = 32'h0000AB00;
        #1;
        chk("rmw_gnt", bus0.d_gnt, 1'b1);
        chk("rmw_rd_csb", csb0, 1'b0);
        chk("rmw_rd_web", web0, 1'b1);
        chk("rmw_rd_addr", addr0, 8'h08);
        @(negedge clk);
        bus0.d_req = 1'b0; bus0.i_req = 1'b1; bus0.i_addr = 10'h000;
        #1;
        chk("rmw_cap_ignt", bus0.i_gnt, 1'b0);
        chk("rmw_cap_csb", csb0, 1'b1);
        @(negedge clk); #1;
        chk("rmw_wr_ignt", bus0.i_gnt, 1'b0);
        chk("rmw_wr_csb", csb0, 1'b0);
        chk("rmw_wr_web", web0, 1'b0);
        chk("rmw_wr_addr", addr0, 8'h08);
        chk("rmw_wr_din", din0, 32'h1122AB44);
        @(negedge clk); #1;
        chk("rmw_d_valid", bus0.d_rvalid, 1'b1);
        chk("rmw_idle_ignt", bus0.i_gnt, 1'b1);
        @(negedge clk);
        bus0.i_req = 1'b0;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 10'h020;
        #1;
        chk("rmw_ld_gnt", bus0.d_gnt, 1'b1);
        @(negedge clk); bus0.d_req = 1'b0; #1;
        chk("rmw_fetch_valid", bus0.i_rvalid, 1'b1);
        @(negedge clk); #1;
        chk("rmw_ld_valid", bus0.d_rvalid, 1'b1);
        chk("rmw_ld_rdata", bus0.d_rdata, 32'h1122AB44);

        // Zero-enable store on the round-robin instance: no access, ack next cycle
        @(negedge clk);
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_be = 4'h0;
        bus1.d_addr = 10'h00C; bus1.d_wdata = 32'h55555555;
        #1;
        chk("be0_gnt", bus1.d_gnt, 1'b1);
        chk("be0_csb", csb1, 1'b1);
        @(negedge clk); bus1.d_req = 1'b0; #1;
        chk("be0_valid", bus1.d_rvalid, 1'b1);
        chk("be0_csb_a1", csb1, 1'b1);
        @(negedge clk); #1;
        chk("be0_pulse", bus1.d_rvalid, 1'b0);

        // Reset during RMW capture: no write may reach the macro
        mem0[9] = 32'hCAFEF00D; ref0[9] = 32'hCAFEF00D;
        @(negedge clk);
        bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_be = 4'b0001;
        bus0.d_addr = 10'h024; bus0.d_wdata = 32'h000000EE;
        #1;
        chk("rst_rmw_gnt", bus0.d_gnt, 1'b1);
        @(negedge clk);
        bus0.d_req = 1'b0;
        wsave  = wr_cnt0;
        rst0_n = 1'b0;
        #1;
        chk("rst_rmw_csb", csb0, 1'b1);
        chk("rst_rmw_web", web0, 1'b1);
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rst_rmw_no_valid", bus0.d_rvalid, 1'b0);
        end
        chk("rst_rmw_no_write", wr_cnt0, wsave);
        chk("rst_rmw_word", mem0[9], 32'hCAFEF00D);

        // Random single transactions against the reference memory
        for (int n = 0; n < 60; n++) begin
            txn0($urandom_range(0, 2), 8'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < 16; i++) begin
            chk("final_mem", mem0[i], ref0[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
